rv32i_encoder: RTL and testbench
================================

# rv32i_encoder

Streaming RV32I instruction encoder: accepts one symbolic instruction request per cycle (opcode selector, register fields, 32-bit immediate) and emits the matching 32-bit uncompressed instruction word, performing the field packing and immediate scattering that the decoder undoes. It sits between the test/bootstrap sequencer and instruction memory, and feeds self-check loops through the decoder. The optional `LI` pseudo-op expands into up to two words through a small state machine. Both sides use valid/ready handshakes.

## Interface
- No parameters.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_req_valid` input 1: request present.
- `o_req_ready` output 1: request accepted on a cycle where valid && ready.
- `i_req_op` input 6: selector. 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4–9 BEQ BNE BLT BGE BLTU BGEU, 10–14 LB LH LW LBU LHU, 15–17 SB SH SW, 18–26 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI, 27–36 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, 37 ECALL, 38 EBREAK, 39 LI. All other values are illegal.
- `i_req_rd`, `i_req_rs1`, `i_req_rs2` input 5 each: register indices. Fields unused by the format are ignored.
- `i_req_imm` input 32: immediate, byte offset, signed unless stated otherwise.
- `o_inst_valid` output 1: `o_inst` holds a word.
- `i_inst_ready` input 1: downstream accepts the word.
- `o_inst` output 32: encoded instruction; bits [1:0] are always 2'b11.
- `o_err` output 1: one-cycle pulse when a rejected request is accepted.

## Operation
- Legality checks:
  - I/S-type: imm must sign-fit 12 bits.
  - B-type: sign-fit 13 bits and imm[0]=0.
  - JAL: sign-fit 21 bits and imm[0]=0.
  - U-type: imm[11:0]=0; the word uses imm[31:12].
  - Shift-immediates: imm[31:5]=0.
  - Any illegal selector is rejected.
- A rejected request is still consumed (ready rule unchanged). It produces no word; `o_err` pulses the next cycle.
- Fixed fields:
  - SUB, SRA, SRAI: funct7=0100000. All other R-type and shifts: funct7=0000000.
  - ECALL emits 0x00000073 and EBREAK emits 0x00100073; register and imm inputs are ignored.
  - Loads, JALR and I-ALU use funct3 per the RV32I base table.
- State machine: IDLE, LI2.
  - LI with imm sign-fitting 12 bits: emit ADDI rd,x0,imm. Stay in IDLE.
  - Other LI: hi = (imm + 0x800) >> 12, computed mod 2^32 and truncated to 20 bits. Emit LUI rd,hi.
  - If imm[11:0] ≠ 0: go to LI2, then emit ADDI rd,rd,imm[11:0] and return to IDLE. If imm[11:0] = 0: emit LUI only.
  - LI2 holds rd and imm[11:0] in internal registers.
- `o_req_ready` = i_rst_n && state==IDLE && (!o_inst_valid || i_inst_ready).
- Reset (any time, including in LI2): state→IDLE, o_inst_valid=0, o_inst=0, o_err=0. A pending second LI word is discarded.

## Timing
- Latency: request accepted at edge N → word valid from edge N (visible in cycle N+1). Throughput: one word per cycle under continuous ready.
- Output register: `o_inst` and `o_inst_valid` are registered. While o_inst_valid && !i_inst_ready, `o_inst` is held stable and no request is accepted.
- LI2: the second word loads at the edge where the first word is taken. `o_req_ready` stays low until the edge after that load.
- `o_err` is registered and asserts for exactly one cycle per rejected request. It never coincides with a new word from the same request.
- No combinational path from `i_req_*` to `o_inst`. A combinational path exists from `i_inst_ready` to `o_req_ready`.

## Configuration
- `ENCODER_PSEUDO_EN` defined: LI (op 39) is supported as above, including the LI2 state.
- Not defined: op 39 is illegal (consumed, o_err pulses), the state machine reduces to IDLE only, and no LI2 registers are built.

## Test plan
- ADDI x1,x0,5 with downstream always ready → 0x00500093 one cycle after acceptance; o_err stays 0.
- SUB x3,x1,x2 then ECALL back-to-back → 0x402081B3 then 0x00000073 on consecutive cycles.
- LI x5,0x12345678 (macro defined) → 0x123452B7 then 0x67828293; o_req_ready low for the cycle between them. LI x5,0x800 → 0x000012B7 then 0x80028293. LI x5,-1 → the single word 0xFFF00293.
- BEQ with imm=3, then SLLI with imm=32, then op 50 → three o_err pulses, no o_inst_valid. With the macro undefined, LI → o_err pulse.
- Backpressure: i_inst_ready low for 4 cycles after ADDI is accepted → o_inst stays 0x00500093, o_req_ready=0, and a following request is held until ready returns.
- Reset asserted in LI2 → o_inst_valid=0 and o_inst=0 immediately; after release the next request encodes normally and no stale ADDI appears.

Source files
------------

// File: rtl/rv32i_encoder.sv
// Streaming RV32I encoder: symbolic request in, packed 32-bit instruction word out, valid/ready on both sides.
// Define ENCODER_PSEUDO_EN to build the LI pseudo-op (op 39) and its two-word LI2 sequence.
module rv32i_encoder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_req_op,
  input  logic [4:0]  i_req_rd,
  input  logic [4:0]  i_req_rs1,
  input  logic [4:0]  i_req_rs2,
  input  logic [31:0] i_req_imm,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic        o_err
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [3:0] {
    FMT_BAD, FMT_U, FMT_J, FMT_I, FMT_B, FMT_S, FMT_SH, FMT_R, FMT_SYS, FMT_LI
  } fmt_t;

  fmt_t        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] sys_word;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic        enc_li2;

  logic        fits12, fits13, fits21;
  logic        accept, take, in_li2;

  assign fits12 = (i_req_imm[31:11] == '0) || (i_req_imm[31:11] == '1);
  assign fits13 = (i_req_imm[31:12] == '0) || (i_req_imm[31:12] == '1);
  assign fits21 = (i_req_imm[31:20] == '0) || (i_req_imm[31:20] == '1);

  // Selector decode: format class plus the fixed opcode/funct fields.
  always_comb begin
    fmt      = FMT_BAD;
    opc      = '0;
    f3       = '0;
    f7       = '0;
    sys_word = '0;
    case (i_req_op)
      6'd0:  begin fmt = FMT_U; opc = OPC_LUI;   end
      6'd1:  begin fmt = FMT_U; opc = OPC_AUIPC; end
      6'd2:  begin fmt = FMT_J; opc = OPC_JAL;   end
      6'd3:  begin fmt = FMT_I; opc = OPC_JALR;  end
      6'd4:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b000; end
      6'd5:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b001; end
      6'd6:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b100; end
      6'd7:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b101; end
      6'd8:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b110; end
      6'd9:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b111; end
      6'd10: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b000; end
      6'd11: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b001; end
      6'd12: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b010; end
      6'd13: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b100; end
      6'd14: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b101; end
      6'd15: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b000; end
      6'd16: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b001; end
      6'd17: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b010; end
      6'd18: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b000; end
      6'd19: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b010; end
      6'd20: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b011; end
      6'd21: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b100; end
      6'd22: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b110; end
      6'd23: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b111; end
      6'd24: begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b001; end
      6'd25: begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; end
      6'd26: begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; f7 = F7_ALT; end
      6'd27: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b000; end
      6'd28: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b000; f7 = F7_ALT; end
      6'd29: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b001; end
      6'd30: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b010; end
      6'd31: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b011; end
      6'd32: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b100; end
      6'd33: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b101; end
      6'd34: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b101; f7 = F7_ALT; end
      6'd35: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b110; end
      6'd36: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b111; end
      6'd37: begin fmt = FMT_SYS; sys_word = 32'h0000_0073; end
      6'd38: begin fmt = FMT_SYS; sys_word = 32'h0010_0073; end
`ifdef ENCODER_PSEUDO_EN
      6'd39: fmt = FMT_LI;
`endif
      default: fmt = FMT_BAD;
    endcase
  end

`ifdef ENCODER_PSEUDO_EN
  logic [31:0] imm_round;
  // LUI part is rounded so the sign-extended low 12 bits of the ADDI land on imm.
  assign imm_round = i_req_imm + 32'h0000_0800;
`endif

  // Field packing and immediate legality.
  always_comb begin
    enc_legal = 1'b0;
    enc_word  = '0;
    enc_li2   = 1'b0;
    case (fmt)
      FMT_U: begin
        enc_legal = (i_req_imm[11:0] == '0);
        enc_word  = {i_req_imm[31:12], i_req_rd, opc};
      end
      FMT_J: begin
        enc_legal = fits21 && !i_req_imm[0];
        enc_word  = {i_req_imm[20], i_req_imm[10:1], i_req_imm[11], i_req_imm[19:12],
                     i_req_rd, opc};
      end
      FMT_I: begin
        enc_legal = fits12;
        enc_word  = {i_req_imm[11:0], i_req_rs1, f3, i_req_rd, opc};
      end
      FMT_B: begin
        enc_legal = fits13 && !i_req_imm[0];
        enc_word  = {i_req_imm[12], i_req_imm[10:5], i_req_rs2, i_req_rs1, f3,
                     i_req_imm[4:1], i_req_imm[11], opc};
      end
      FMT_S: begin
        enc_legal = fits12;
        enc_word  = {i_req_imm[11:5], i_req_rs2, i_req_rs1, f3, i_req_imm[4:0], opc};
      end
      FMT_SH: begin
        enc_legal = (i_req_imm[31:5] == '0);
        enc_word  = {f7, i_req_imm[4:0], i_req_rs1, f3, i_req_rd, opc};
      end
      FMT_R: begin
        enc_legal = 1'b1;
        enc_word  = {f7, i_req_rs2, i_req_rs1, f3, i_req_rd, opc};
      end
      FMT_SYS: begin
        enc_legal = 1'b1;
        enc_word  = sys_word;
      end
`ifdef ENCODER_PSEUDO_EN
      FMT_LI: begin
        enc_legal = 1'b1;
        if (fits12) begin
          enc_word = {i_req_imm[11:0], 5'd0, 3'b000, i_req_rd, OPC_OPIMM};
        end else begin
          enc_word = {imm_round[31:12], i_req_rd, OPC_LUI};
          enc_li2  = (i_req_imm[11:0] != '0);
        end
      end
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  assign take = o_inst_valid && i_inst_ready;

`ifdef ENCODER_PSEUDO_EN
  typedef enum logic {IDLE, LI2} state_t;
  state_t      state, state_next;
  logic [4:0]  li_rd;
  logic [11:0] li_lo;

  assign in_li2 = (state == LI2);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && enc_legal && enc_li2) state_next = LI2;
      LI2:     if (take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      li_rd <= '0;
      li_lo <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        li_rd <= i_req_rd;
        li_lo <= i_req_imm[11:0];
      end
    end
  end
`else
  assign in_li2 = 1'b0;
`endif

  always_comb begin
    o_req_ready = i_rst_n && !in_li2 && (!o_inst_valid || i_inst_ready);
  end

  assign accept = i_req_valid && o_req_ready;

  // A rejected request also retires the current word, since accept implies it was taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inst_valid <= 1'b0;
      o_inst       <= '0;
      o_err        <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (accept) begin
        if (enc_legal) begin
          o_inst       <= enc_word;
          o_inst_valid <= 1'b1;
        end else begin
          o_inst_valid <= 1'b0;
          o_err        <= 1'b1;
        end
`ifdef ENCODER_PSEUDO_EN
      end else if (in_li2 && take) begin
        o_inst       <= {li_lo, li_rd, 3'b000, li_rd, OPC_OPIMM};
        o_inst_valid <= 1'b1;
`endif
      end else if (take) begin
        o_inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Bench for rv32i_encoder: directed scenarios, then random requests with random backpressure
// checked against an arithmetic encoding model. Honours ENCODER_PSEUDO_EN like the design.
module tb_rv32i_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [5:0]  i_req_op = '0;
  logic [4:0]  i_req_rd = '0;
  logic [4:0]  i_req_rs1 = '0;
  logic [4:0]  i_req_rs2 = '0;
  logic [31:0] i_req_imm = '0;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic [31:0] o_inst;
  logic        o_err;

  int tests = 0;
  int failed = 0;
  bit mon_en = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  rv32i_encoder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_rd(i_req_rd), .i_req_rs1(i_req_rs1),
    .i_req_rs2(i_req_rs2), .i_req_imm(i_req_imm),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst(o_inst), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Transfer log: words on handshake, error pulses as tagged entries.
  always @(negedge i_clk) begin
    if (mon_en && i_rst_n) begin
      if (o_inst_valid && i_inst_ready) got_q.push_back({1'b0, o_inst});
      if (o_err) got_q.push_back({1'b1, 32'h0});
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_rd    = rd;
    i_req_rs1   = rs1;
    i_req_rs2   = rs2;
    i_req_imm   = imm;
  endtask

  function automatic logic [31:0] itype(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] opc);
    return ((imm % 32'd4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + opc;
  endfunction

  // Reference: encoding computed from the instruction-set field layout with plain arithmetic.
  task automatic model(input logic [5:0] op, input logic [4:0] rd5, input logic [4:0] rs15,
                       input logic [4:0] rs25, input logic [31:0] imm);
    int s;
    logic [31:0] rd, rs1, rs2, w, hi, f3, f7;
    bit ok;
    logic [31:0] br_f3[6] = '{32'd0, 32'd1, 32'd4, 32'd5, 32'd6, 32'd7};
    logic [31:0] ld_f3[5] = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5};
    logic [31:0] ai_f3[6] = '{32'd0, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7};
    logic [31:0] r_f3[10] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5, 32'd6, 32'd7};
    s   = $signed(imm);
    rd  = 32'(rd5);
    rs1 = 32'(rs15);
    rs2 = 32'(rs25);
    ok  = 1'b0;
    w   = '0;
    if (op <= 6'd1) begin
      ok = (imm % 32'd4096) == 0;
      w  = imm - (imm % 32'd4096) + (rd << 7) + ((op == 6'd0) ? 32'h37 : 32'h17);
    end else if (op == 6'd2) begin
      ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
      w  = (((imm >> 20) % 32'd2) << 31) + (((imm >> 1) % 32'd1024) << 21) +
           (((imm >> 11) % 32'd2) << 20) + (((imm >> 12) % 32'd256) << 12) + (rd << 7) + 32'h6F;
    end else if (op == 6'd3) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = itype(imm, rs1, 32'd0, rd, 32'h67);
    end else if (op <= 6'd9) begin
      ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      f3 = br_f3[op - 6'd4];
      w  = (((imm >> 12) % 32'd2) << 31) + (((imm >> 5) % 32'd64) << 25) + (rs2 << 20) +
           (rs1 << 15) + (f3 << 12) + (((imm >> 1) % 32'd16) << 8) +
           (((imm >> 11) % 32'd2) << 7) + 32'h63;
    end else if (op <= 6'd14) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = itype(imm, rs1, ld_f3[op - 6'd10], rd, 32'h03);
    end else if (op <= 6'd17) begin
      ok = (s >= -2048) && (s <= 2047);
      f3 = 32'(op - 6'd15);
      w  = (((imm >> 5) % 32'd128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) +
           ((imm % 32'd32) << 7) + 32'h23;
    end else if (op <= 6'd23) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = itype(imm, rs1, ai_f3[op - 6'd18], rd, 32'h13);
    end else if (op <= 6'd26) begin
      ok = imm < 32'd32;
      f3 = (op == 6'd24) ? 32'd1 : 32'd5;
      f7 = (op == 6'd26) ? 32'd32 : 32'd0;
      w  = (f7 << 25) + ((imm % 32'd32) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
    end else if (op <= 6'd36) begin
      ok = 1'b1;
      f7 = (op == 6'd28 || op == 6'd34) ? 32'd32 : 32'd0;
      w  = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (r_f3[op - 6'd27] << 12) + (rd << 7) + 32'h33;
    end else if (op == 6'd37) begin
      ok = 1'b1; w = 32'h0000_0073;
    end else if (op == 6'd38) begin
      ok = 1'b1; w = 32'h0010_0073;
`ifdef ENCODER_PSEUDO_EN
    end else if (op == 6'd39) begin
      if ((s >= -2048) && (s <= 2047)) begin
        exp_q.push_back({1'b0, itype(imm, 32'd0, 32'd0, rd, 32'h13)});
      end else begin
        hi = (imm + 32'd2048) >> 12;
        exp_q.push_back({1'b0, (hi << 12) + (rd << 7) + 32'h37});
        if ((imm % 32'd4096) != 0)
          exp_q.push_back({1'b0, itype(imm, rd, 32'd0, rd, 32'h13)});
      end
      return;
`endif
    end
    if (ok) exp_q.push_back({1'b0, w});
    else    exp_q.push_back({1'b1, 32'h0});
  endtask

  task automatic send_random(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
    bit accepted = 1'b0;
    drive(op, rd, rs1, rs2, imm);
    for (int c = 0; c < 200 && !accepted; c++) begin
      i_inst_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (o_req_ready) accepted = 1'b1;
      step();
    end
    i_req_valid = 1'b0;
    tests++;
    assert (accepted) else begin
      failed++;
      $error("FAIL accept_timeout: observed op %0d not accepted expected accepted", op);
    end
  endtask

  logic [31:0] bnd[12] = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094,
                           32'd4096, 32'd31, 32'd32, 32'h000F_FFFE, 32'h0010_0000,
                           32'hFFF0_0000, 32'h7FFF_F800};

  initial begin
    // reset state
    step(); step();
    chk1("rst_valid", o_inst_valid, 1'b0);
    chk("rst_inst", o_inst, 32'h0);
    chk1("rst_err", o_err, 1'b0);
    chk1("rst_ready", o_req_ready, 1'b0);
    i_rst_n = 1'b1;
    i_inst_ready = 1'b1;
    step();

    // ADDI x1,x0,5
    drive(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
    #1 chk1("addi_ready", o_req_ready, 1'b1);
    step();
    i_req_valid = 1'b0;
    chk("addi_word", o_inst, 32'h0050_0093);
    chk1("addi_valid", o_inst_valid, 1'b1);
    chk1("addi_err", o_err, 1'b0);
    step();
    chk1("addi_drain", o_inst_valid, 1'b0);
    chk1("addi_err2", o_err, 1'b0);

    // SUB x3,x1,x2 then ECALL back-to-back
    drive(6'd28, 5'd3, 5'd1, 5'd2, 32'h0);
    step();
    drive(6'd37, 5'd7, 5'd9, 5'd11, 32'h0000_FFFF);
    #1 chk1("ecall_ready", o_req_ready, 1'b1);
    chk("sub_word", o_inst, 32'h4020_81B3);
    step();
    i_req_valid = 1'b0;
    chk("ecall_word", o_inst, 32'h0000_0073);
    chk1("ecall_valid", o_inst_valid, 1'b1);
    step();
    chk1("ecall_drain", o_inst_valid, 1'b0);

`ifdef ENCODER_PSEUDO_EN
    drive(6'd39, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    step();
    i_req_valid = 1'b0;
    chk("li1_lui", o_inst, 32'h1234_52B7);
    chk1("li1_ready_low", o_req_ready, 1'b0);
    step();
    chk("li1_addi", o_inst, 32'h6782_8293);
    chk1("li1_addi_valid", o_inst_valid, 1'b1);
    chk1("li1_ready_back", o_req_ready, 1'b1);
    step();
    drive(6'd39, 5'd5, 5'd0, 5'd0, 32'h0000_0800);
    step();
    i_req_valid = 1'b0;
    chk("li2_lui", o_inst, 32'h0000_12B7);
    step();
    chk("li2_addi", o_inst, 32'h8002_8293);
    step();
    drive(6'd39, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    step();
    i_req_valid = 1'b0;
    chk("li3_word", o_inst, 32'hFFF0_0293);
    chk1("li3_ready", o_req_ready, 1'b1);
    step();
    chk1("li3_single", o_inst_valid, 1'b0);
`else
    drive(6'd39, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    step();
    i_req_valid = 1'b0;
    chk1("li_off_err", o_err, 1'b1);
    chk1("li_off_valid", o_inst_valid, 1'b0);
    step();
    chk1("li_off_err_end", o_err, 1'b0);
`endif

    // illegal requests back-to-back
    drive(6'd4, 5'd0, 5'd1, 5'd2, 32'd3);
    #1 chk1("beq_ready", o_req_ready, 1'b1);
    step();
    drive(6'd24, 5'd1, 5'd2, 5'd0, 32'd32);
    chk1("beq_err", o_err, 1'b1);
    chk1("beq_novalid", o_inst_valid, 1'b0);
    step();
    drive(6'd50, 5'd1, 5'd2, 5'd3, 32'd0);
    chk1("slli_err", o_err, 1'b1);
    chk1("slli_novalid", o_inst_valid, 1'b0);
    step();
    i_req_valid = 1'b0;
    chk1("op50_err", o_err, 1'b1);
    chk1("op50_novalid", o_inst_valid, 1'b0);
    step();
    chk1("err_single", o_err, 1'b0);

    // backpressure
    i_inst_ready = 1'b0;
    drive(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    drive(6'd27, 5'd4, 5'd1, 5'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_hold", o_inst, 32'h0050_0093);
      chk1("bp_ready", o_req_ready, 1'b0);
      chk1("bp_valid", o_inst_valid, 1'b1);
      step();
    end
    i_inst_ready = 1'b1;
    #1 chk1("bp_release", o_req_ready, 1'b1);
    step();
    i_req_valid = 1'b0;
    chk("bp_next", o_inst, 32'h0020_8233);
    step();
    chk1("bp_drain", o_inst_valid, 1'b0);

    // reset with a word pending
`ifdef ENCODER_PSEUDO_EN
    drive(6'd39, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
`else
    drive(6'd18, 5'd2, 5'd0, 5'd0, 32'd7);
`endif
    step();
    i_req_valid = 1'b0;
    i_inst_ready = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", o_inst_valid, 1'b0);
    chk("mid_rst_inst", o_inst, 32'h0);
    chk1("mid_rst_ready", o_req_ready, 1'b0);
    step(); step();
    i_rst_n = 1'b1;
    i_inst_ready = 1'b1;
    drive(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
    #1 chk1("post_rst_ready", o_req_ready, 1'b1);
    step();
    i_req_valid = 1'b0;
    chk("post_rst_word", o_inst, 32'h0050_0093);
    step();
    chk1("no_stale1", o_inst_valid, 1'b0);
    step();
    chk1("no_stale2", o_inst_valid, 1'b0);

    // random traffic against the model
    exp_q.delete();
    got_q.delete();
    mon_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [31:0] imm;
      logic [4:0]  rd, rs1, rs2;
      op  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 39));
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      case ($urandom_range(0, 5))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: imm = bnd[$urandom_range(0, 11)];
        3: imm = $urandom & 32'hFFFF_F000;
        4: imm = 32'($urandom_range(0, 40));
        default: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
      endcase
      model(op, rd, rs1, rs2, imm);
      send_random(op, rd, rs1, rs2, imm);
      if ($urandom_range(0, 4) == 0) begin
        i_inst_ready = ($urandom_range(0, 1) != 0);
        step();
      end
    end
    i_inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    mon_en = 1'b0;
    tests++;
    assert (got_q.size() === exp_q.size()) else begin
      failed++;
      $error("FAIL rand_count: observed %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [32:0] g;
      g = (i < got_q.size()) ? got_q[i] : 33'h1_DEAD_BEEF;
      tests++;
      assert (g === exp_q[i]) else begin
        failed++;
        $error("FAIL rand_item[%0d]: observed %09h expected %09h", i, g, exp_q[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
